ps2_cmd_sequencer: RTL and testbench
====================================

# ps2_cmd_sequencer

Sequences host-to-keyboard commands through the PS/2 controller's send path and shares that path between two requesters (e.g. LED-update and typematic-rate logic). Each transaction is a 1- or 2-byte command. For every byte the block waits for the keyboard's 0xFA acknowledge, resends on 0xFE (resend request) or on timeout, and reports completion per requester. Received bytes that are not command responses go out as a scan-code stream for downstream keyboard logic.

## Interface
Parameters:
- ACK_TIMEOUT_CYCLES, 1000000: CLOCK_50 cycles to wait for a response byte (20 ms). Minimum 4.
- MAX_RETRY, 3: resends allowed per byte after the first attempt (0–7).

Ports:
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  request lines, one per requester. Held high until that requester's done pulse.
- req_cmd  in  16  command bytes: [7:0] requester 0, [15:8] requester 1. Sampled at grant.
- req_arg  in  16  argument bytes, same packing as req_cmd. Sampled at grant.
- req_has_arg  in  2  per requester: 1 means the transaction is 2 bytes (cmd then arg).
- done  out  2  one-cycle pulse on the granted requester's bit at transaction end.
- err  out  1  valid with done: 1 means retries were exhausted.
- busy  out  1  high in every state except IDLE.
- ps2_the_command  out  8  byte to the PS/2 controller. Stable while ps2_send_command is high.
- ps2_send_command  out  1  send request to the PS/2 controller.
- ps2_command_was_sent  in  1  controller reports the byte went out.
- ps2_error_timed_out  in  1  controller reports a send failure.
- ps2_received_data  in  8  byte from the keyboard.
- ps2_received_data_en  in  1  one-cycle strobe marking ps2_received_data as valid.
- key_data  out  8  forwarded scan code.
- key_valid  out  1  one-cycle strobe for key_data.

## Operation
States are IDLE, SEND, WAIT_ACK and DONE.

- **IDLE**
  - Arbitration is round-robin on req.
  - A pointer records the last-granted requester. It resets so requester 0 wins the first tie.
  - On grant: latch cmd, arg and has_arg; set byte_idx=0 and attempts=0; go to SEND.
- **SEND**
  - Drive ps2_the_command with cmd (byte_idx=0) or arg (byte_idx=1). Hold ps2_send_command high.
  - ps2_command_was_sent: drop send; go to WAIT_ACK with the timeout counter cleared.
  - ps2_error_timed_out: counts as a failed attempt (retry rule). It wins over was_sent in the same cycle.
- **WAIT_ACK**
  - The counter increments every cycle.
  - Strobe with data 0xFA:
    - If byte_idx=0 and has_arg: set byte_idx=1, attempts=0, go to SEND.
    - Otherwise: go to DONE with err=0.
  - Strobe with data 0xFE: failed attempt.
  - Counter reaches ACK_TIMEOUT_CYCLES-1 with no 0xFA/0xFE: failed attempt. A 0xFA or 0xFE in that same cycle wins.
  - Any other received byte is forwarded. It does not reset the counter.
- **Retry rule**
  - If attempts < MAX_RETRY: attempts++ and go back to SEND with the same byte.
  - Otherwise: go to DONE with err=1.
  - Each byte is sent at most MAX_RETRY+1 times.
- **DONE**
  - done[granted]=1 and err valid for one cycle.
  - Update the round-robin pointer to the granted requester.
  - Go to IDLE.
- **Forwarding**
  - In IDLE, SEND and DONE every strobe is forwarded.
  - In WAIT_ACK only 0xFA and 0xFE are consumed; all other bytes are forwarded.
- **Requester rules**
  - req is sampled only in IDLE. Changes to req, cmd or arg after grant are ignored.
  - req still high in the cycle after done is treated as a new request.

## Timing
- Reset values (asynchronous, immediate): all outputs 0. State=IDLE, pointer points at requester 1 (so requester 0 wins the first tie), counters 0. Reset mid-transaction drops ps2_send_command at once and no done is emitted.
- Grant latency: req seen in IDLE at cycle N gives ps2_send_command=1 at N+1.
- Resend latency: an ACK or failure at cycle N gives send=1 again at N+1 (next byte or retry).
- Done latency: ACK of the final byte at cycle N gives DONE state and the done pulse at N+1, and IDLE at N+2. A new grant is possible at N+2, with send at N+3.
- Forward latency: key_valid and key_data are registered one cycle after ps2_received_data_en.
- Width rules:
  - Timeout counter is clog2(ACK_TIMEOUT_CYCLES) bits and never wraps; it is cleared on entry to WAIT_ACK.
  - attempts is 3 bits.

## Test plan
- **Single-byte command, immediate ACK.** Requester 0 sends cmd=0xF4, has_arg=0. Model was_sent 3 cycles after send, then 0xFA 5 cycles later. Expect ps2_the_command=0xF4 while send is high, done=2'b01 with err=0, and no key_valid.
- **Two-byte command with one resend.** Requester 1 sends 0xED with arg 0x07. Keyboard responds 0xFA, then 0xFE, then 0xFA. Expect the send sequence 0xED, 0x07, 0x07, then done=2'b10 with err=0.
- **Timeout exhaustion.** ACK_TIMEOUT_CYCLES=16, MAX_RETRY=2, keyboard never responds. Expect exactly 3 sends of cmd, then done with err=1 about 3×(16+send latency) cycles after grant.
- **Arbitration fairness.** Both req held high continuously. Expect grants to alternate 0, 1, 0, 1. Expect requester 0 first after reset.
- **Scan-code interleave.** Inject 0x1C during WAIT_ACK, then 0xFA. Expect key_valid with key_data=0x1C one cycle after its strobe, and the transaction to complete normally. A 0xFA arriving in IDLE is forwarded.
- **Reset mid-SEND and simultaneous events.** Assert reset while send=1: send drops in the same cycle and no done follows. Assert was_sent and timed_out in the same cycle: expect a retry.

Source files
------------

// File: rtl/ps2_cmd_sequencer.sv
// ps2_cmd_sequencer
//   Shares the PS/2 controller's send path between two requesters and runs
//   1- or 2-byte host-to-keyboard commands. Each byte is resent on a 0xFE
//   reply, a controller send failure or a response timeout, up to MAX_RETRY
//   resends. Received bytes that are not command responses are forwarded as
//   a scan-code stream.
//
// Ports
//   CLOCK_50, reset            clock, asynchronous active-high reset
//   req[1:0]                   request lines, held until the matching done
//   req_cmd/req_arg[15:0]      per-requester command/argument bytes
//   req_has_arg[1:0]           per-requester: transaction has an argument byte
//   done[1:0], err             end-of-transaction pulse, err = retries exhausted
//   busy                       transaction in progress
//   ps2_the_command/ps2_send_command          byte and send request to controller
//   ps2_command_was_sent/ps2_error_timed_out  controller send status
//   ps2_received_data/ps2_received_data_en    byte from the keyboard
//   key_data/key_valid         forwarded scan code, registered
module ps2_cmd_sequencer #(
  parameter int ACK_TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY          = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [15:0] req_cmd,
  input  logic [15:0] req_arg,
  input  logic [1:0]  req_has_arg,
  output logic [1:0]  done,
  output logic        err,
  output logic        busy,
  output logic [7:0]  ps2_the_command,
  output logic        ps2_send_command,
  input  logic        ps2_command_was_sent,
  input  logic        ps2_error_timed_out,
  input  logic [7:0]  ps2_received_data,
  input  logic        ps2_received_data_en,
  output logic [7:0]  key_data,
  output logic        key_valid
);

  localparam int              CNT_W     = $clog2(ACK_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      RETRY_MAX = 3'(MAX_RETRY);
  localparam logic [7:0]      RSP_ACK   = 8'hFA;
  localparam logic [7:0]      RSP_RESEND = 8'hFE;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, DONE} state_t;

  state_t           state, state_nxt;
  logic             gnt_q, gnt_nxt;       // requester owning the current transaction
  logic             ptr_q;                // last requester that completed
  logic             byte_idx_q, byte_idx_nxt;
  logic [2:0]       att_q, att_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             err_q, err_nxt;
  logic             load;
  logic             fail;
  logic             fwd;
  logic [7:0]       cmd_q, arg_q;
  logic             has_arg_q;
  logic [7:0]       key_data_p1;
  logic             vld_p1;

  logic rx_ack, rx_resend;
  assign rx_ack    = ps2_received_data_en && (ps2_received_data == RSP_ACK);
  assign rx_resend = ps2_received_data_en && (ps2_received_data == RSP_RESEND);

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt_q;
    byte_idx_nxt = byte_idx_q;
    att_nxt      = att_q;
    cnt_nxt      = cnt_q;
    err_nxt      = err_q;
    load         = 1'b0;
    fail         = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          // On a tie the requester that did not finish last wins.
          gnt_nxt      = (req == 2'b11) ? ~ptr_q : req[1];
          load         = 1'b1;
          byte_idx_nxt = 1'b0;
          att_nxt      = 3'd0;
          err_nxt      = 1'b0;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        // A controller failure outranks a simultaneous was_sent.
        if (ps2_error_timed_out) begin
          fail = 1'b1;
        end else if (ps2_command_was_sent) begin
          cnt_nxt   = '0;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (cnt_q != CNT_LAST) cnt_nxt = cnt_q + CNT_W'(1);
        // A response arriving on the last counted cycle beats the timeout.
        if (rx_ack) begin
          if (!byte_idx_q && has_arg_q) begin
            byte_idx_nxt = 1'b1;
            att_nxt      = 3'd0;
            state_nxt    = SEND;
          end else begin
            err_nxt   = 1'b0;
            state_nxt = DONE;
          end
        end else if (rx_resend || (cnt_q == CNT_LAST)) begin
          fail = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (fail) begin
      if (att_q < RETRY_MAX) begin
        att_nxt   = att_q + 3'd1;
        state_nxt = SEND;
      end else begin
        err_nxt   = 1'b1;
        state_nxt = DONE;
      end
    end
  end

  // WAIT_ACK swallows only the two command responses; everything else is a scan code.
  assign fwd = ps2_received_data_en && !((state == WAIT_ACK) && (rx_ack || rx_resend));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gnt_q       <= 1'b0;
      ptr_q       <= 1'b1;
      byte_idx_q  <= 1'b0;
      att_q       <= 3'd0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      vld_p1      <= 1'b0;
      key_data_p1 <= 8'h00;
    end else begin
      state      <= state_nxt;
      gnt_q      <= gnt_nxt;
      byte_idx_q <= byte_idx_nxt;
      att_q      <= att_nxt;
      cnt_q      <= cnt_nxt;
      err_q      <= err_nxt;
      if (state == DONE) ptr_q <= gnt_q;
      // ---- forward stage p1 ----
      vld_p1 <= fwd;
      if (fwd) key_data_p1 <= ps2_received_data;
    end
  end

  // Transaction payload, captured at grant and ignored thereafter.
  always_ff @(posedge CLOCK_50) begin
    if (load) begin
      cmd_q     <= gnt_nxt ? req_cmd[15:8] : req_cmd[7:0];
      arg_q     <= gnt_nxt ? req_arg[15:8] : req_arg[7:0];
      has_arg_q <= gnt_nxt ? req_has_arg[1] : req_has_arg[0];
    end
  end

  assign ps2_send_command = (state == SEND);
  assign ps2_the_command  = (state == SEND) ? (byte_idx_q ? arg_q : cmd_q) : 8'h00;
  assign busy             = (state != IDLE);
  assign done             = (state == DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign err              = (state == DONE) && err_q;
  assign key_data         = key_data_p1;
  assign key_valid        = vld_p1;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Testbench for ps2_cmd_sequencer: table-driven transactions, hand-written
// reset/fairness/forwarding sequences and randomized transactions checked
// against a transaction-level reference model.
module tb_ps2_cmd_sequencer;

  localparam int ACK_TO = 16;
  localparam int MAXR   = 2;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] req_cmd = 16'h0;
  logic [15:0] req_arg = 16'h0;
  logic [1:0]  req_has_arg = 2'b00;
  logic [1:0]  done;
  logic        err;
  logic        busy;
  logic [7:0]  ps2_the_command;
  logic        ps2_send_command;
  logic        ps2_command_was_sent = 1'b0;
  logic        ps2_error_timed_out = 1'b0;
  logic [7:0]  ps2_received_data = 8'h00;
  logic        ps2_received_data_en = 1'b0;
  logic [7:0]  key_data;
  logic        key_valid;

  ps2_cmd_sequencer #(.ACK_TIMEOUT_CYCLES(ACK_TO), .MAX_RETRY(MAXR)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .req(req), .req_cmd(req_cmd),
    .req_arg(req_arg), .req_has_arg(req_has_arg), .done(done), .err(err),
    .busy(busy), .ps2_the_command(ps2_the_command),
    .ps2_send_command(ps2_send_command),
    .ps2_command_was_sent(ps2_command_was_sent),
    .ps2_error_timed_out(ps2_error_timed_out),
    .ps2_received_data(ps2_received_data),
    .ps2_received_data_en(ps2_received_data_en),
    .key_data(key_data), .key_valid(key_valid)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Response codes per send attempt: 0 = 0xFA, 1 = 0xFE, 2 = silence,
  // 3 = controller reports was_sent and timed_out together.
  typedef struct {
    logic [1:0]  req;
    logic [15:0] cmd;
    logic [15:0] arg;
    logic [1:0]  has;
    logic [11:0] resp;
    bit          noise;
    logic [1:0]  exp_done;
    logic        exp_err;
    int          exp_nsend;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          d_sent = 3;
  int          d_ack = 5;
  bit          noise_en = 0;
  logic [7:0]  noise_byte = 8'h1C;
  bit          hold_req = 0;
  bit          scramble = 0;
  int          resp_q[$];
  int          model_script[$];
  logic [7:0]  sent_q[$];
  logic [7:0]  exp_q[$];
  logic [1:0]  got_done;
  logic        got_err;
  logic [1:0]  exp_done;
  logic        exp_err;
  int          model_last = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  // Plays controller and keyboard for one transaction, logging every byte sent.
  task automatic serve;
    int budget;
    int r;
    int n;
    logic [7:0] b;
    bit fin;
    sent_q.delete();
    got_done = 2'b00;
    got_err = 1'b0;
    fin = 0;
    while (!fin) begin
      budget = 0;
      while (!ps2_send_command && done == 2'b00 && budget < 40) begin
        tick();
        budget++;
      end
      if (done != 2'b00) begin
        got_done = done;
        got_err = err;
        if (!hold_req) req = 2'b00;
        fin = 1;
      end else if (!ps2_send_command) begin
        chk("wait_send_or_done", 32'd0, 32'd1);
        fin = 1;
      end else begin
        b = ps2_the_command;
        sent_q.push_back(b);
        if (scramble) begin
          req_cmd = 16'($urandom);
          req_arg = 16'($urandom);
          req_has_arg = 2'($urandom);
        end
        r = (resp_q.size() > 0) ? resp_q.pop_front() : 2;
        for (int i = 0; i < d_sent; i++) begin
          tick();
          chk("cmd_stable", 32'({ps2_send_command, ps2_the_command}), 32'({1'b1, b}));
        end
        if (r == 3) begin
          ps2_command_was_sent = 1'b1;
          ps2_error_timed_out = 1'b1;
          tick();
          ps2_command_was_sent = 1'b0;
          ps2_error_timed_out = 1'b0;
          chk("retry_after_ctrl_err", 32'(ps2_send_command || done != 2'b00), 32'd1);
        end else begin
          ps2_command_was_sent = 1'b1;
          tick();
          ps2_command_was_sent = 1'b0;
          chk("send_drop", 32'(ps2_send_command), 32'd0);
          if (r == 2) begin
            n = 0;
            while (!(ps2_send_command || done != 2'b00) && n < ACK_TO + 4) begin
              tick();
              n++;
            end
            chk("timeout_len", n, ACK_TO);
          end else begin
            for (int i = 0; i < d_ack; i++) begin
              if (i == 0 && noise_en) begin
                ps2_received_data = noise_byte;
                ps2_received_data_en = 1'b1;
                tick();
                ps2_received_data_en = 1'b0;
                chk("noise_fwd", 32'({key_valid, key_data}), 32'({1'b1, noise_byte}));
              end else begin
                tick();
              end
            end
            ps2_received_data = (r == 0) ? 8'hFA : 8'hFE;
            ps2_received_data_en = 1'b1;
            tick();
            ps2_received_data_en = 1'b0;
            chk("rsp_consumed", 32'(key_valid), 32'd0);
            chk("after_rsp_latency", 32'(ps2_send_command || done != 2'b00), 32'd1);
          end
        end
      end
    end
  endtask

  // Transaction-level expectation: which requester wins, which bytes go out
  // and whether the retry budget runs out.
  task automatic model_txn(input logic [1:0] rq, input logic [15:0] c,
                           input logic [15:0] a, input logic [1:0] h);
    int w;
    int nbytes;
    int tries;
    int r;
    bit ok;
    logic [7:0] bytes [2];
    if (rq == 2'b11) w = (model_last == 0) ? 1 : 0;
    else w = (rq == 2'b10) ? 1 : 0;
    nbytes = h[w] ? 2 : 1;
    bytes[0] = c[w*8 +: 8];
    bytes[1] = a[w*8 +: 8];
    exp_q.delete();
    exp_err = 1'b0;
    for (int bi = 0; bi < nbytes; bi++) begin
      tries = 0;
      ok = 0;
      while (!ok && tries <= MAXR) begin
        exp_q.push_back(bytes[bi]);
        r = (model_script.size() > 0) ? model_script.pop_front() : 2;
        tries++;
        if (r == 0) ok = 1;
      end
      if (!ok) begin
        exp_err = 1'b1;
        break;
      end
    end
    exp_done = (w == 1) ? 2'b10 : 2'b01;
    model_last = w;
  endtask

  vec_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int rq;
    int c;
    logic [15:0] rc, ra;
    logic [1:0] rh;

    tbl[0] = '{2'b01, 16'h00F4, 16'h0000, 2'b00, 12'h000, 0, 2'b01, 1'b0, 1, 8'hF4, 8'hF4};
    tbl[1] = '{2'b10, 16'hED00, 16'h0700, 2'b10, 12'h004, 0, 2'b10, 1'b0, 3, 8'hED, 8'h07};
    tbl[2] = '{2'b01, 16'h00FF, 16'h0000, 2'b00, 12'h02A, 0, 2'b01, 1'b1, 3, 8'hFF, 8'hFF};
    tbl[3] = '{2'b10, 16'hF300, 16'h2000, 2'b10, 12'h054, 0, 2'b10, 1'b1, 4, 8'hF3, 8'h20};
    tbl[4] = '{2'b01, 16'h00EE, 16'h0000, 2'b00, 12'h003, 1, 2'b01, 1'b0, 2, 8'hEE, 8'hEE};
    tbl[5] = '{2'b11, 16'h2211, 16'h4433, 2'b11, 12'h000, 0, 2'b10, 1'b0, 2, 8'h22, 8'h44};
    tbl[6] = '{2'b11, 16'h2211, 16'h4433, 2'b11, 12'h001, 0, 2'b01, 1'b0, 3, 8'h11, 8'h33};

    // Reset values, asynchronous.
    #1 reset = 1'b1;
    #2;
    chk("rst_outputs", 32'({done, err, busy, ps2_send_command, ps2_the_command, key_valid, key_data}), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("idle_after_rst", 32'({busy, done}), 32'd0);

    // Table-driven transactions.
    for (int v = 0; v < 7; v++) begin
      req_cmd = tbl[v].cmd;
      req_arg = tbl[v].arg;
      req_has_arg = tbl[v].has;
      noise_en = tbl[v].noise;
      noise_byte = 8'h1C;
      d_sent = 3;
      d_ack = 5;
      resp_q.delete();
      for (int k = 0; k < 6; k++) resp_q.push_back(int'(tbl[v].resp[2*k +: 2]));
      req = tbl[v].req;
      tick();
      chk("grant_latency", 32'(ps2_send_command), 32'd1);
      serve();
      chk("tbl_done", 32'(got_done), 32'(tbl[v].exp_done));
      chk("tbl_err", 32'(got_err), 32'(tbl[v].exp_err));
      chk("tbl_nsend", sent_q.size(), tbl[v].exp_nsend);
      if (sent_q.size() > 0) begin
        chk("tbl_first", 32'(sent_q[0]), 32'(tbl[v].exp_first));
        chk("tbl_last", 32'(sent_q[sent_q.size()-1]), 32'(tbl[v].exp_last));
      end
      tick();
      chk("done_one_cycle", 32'({done, busy}), 32'd0);
    end
    noise_en = 0;

    // 0xFA seen while idle is just a scan code.
    ps2_received_data = 8'hFA;
    ps2_received_data_en = 1'b1;
    tick();
    ps2_received_data_en = 1'b0;
    chk("idle_fa_fwd", 32'({key_valid, key_data}), 32'({1'b1, 8'hFA}));
    tick();
    chk("fwd_one_cycle", 32'(key_valid), 32'd0);

    // Reset while a byte is being sent.
    req_cmd = 16'h0055;
    req_has_arg = 2'b00;
    req = 2'b01;
    tick();
    chk("midsend_send", 32'(ps2_send_command), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midsend_rst_drop", 32'({ps2_send_command, busy, ps2_the_command}), 32'd0);
    tick();
    req = 2'b00;
    tick();
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done != 2'b00 || busy) nd++;
    end
    chk("no_done_after_rst", nd, 0);

    // Fairness with both requests held high; pointer was reset.
    req_cmd = 16'h2211;
    req_has_arg = 2'b00;
    d_sent = 1;
    d_ack = 1;
    hold_req = 1;
    req = 2'b11;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("fair_grant", 32'(ps2_the_command), ((i % 2) == 0) ? 32'h11 : 32'h22);
      resp_q.delete();
      resp_q.push_back(0);
      serve();
      chk("fair_done", 32'(got_done), ((i % 2) == 0) ? 32'd1 : 32'd2);
      if (i == 3) req = 2'b00;
      tick();
      chk("fair_idle", 32'(busy), 32'd0);
      tick();
    end
    hold_req = 0;
    model_last = 1;

    // Randomized transactions against the reference model.
    scramble = 1;
    for (int t = 0; t < 40; t++) begin
      rq = $urandom_range(1, 3);
      rc = 16'($urandom);
      ra = 16'($urandom);
      rh = 2'($urandom);
      d_sent = $urandom_range(0, 3);
      d_ack = $urandom_range(0, 14);
      noise_en = 1'($urandom);
      noise_byte = 8'($urandom_range(0, 249));
      resp_q.delete();
      model_script.delete();
      for (int k = 0; k < 6; k++) begin
        c = $urandom_range(0, 9);
        c = (c <= 5) ? 0 : (c <= 7) ? 1 : (c == 8) ? 2 : 3;
        resp_q.push_back(c);
        model_script.push_back(c);
      end
      model_txn(2'(rq), rc, ra, rh);
      req_cmd = rc;
      req_arg = ra;
      req_has_arg = rh;
      req = 2'(rq);
      tick();
      chk("rnd_grant_latency", 32'(ps2_send_command), 32'd1);
      serve();
      chk("rnd_nsend", sent_q.size(), exp_q.size());
      for (int k = 0; k < sent_q.size() && k < exp_q.size(); k++)
        chk("rnd_byte", 32'(sent_q[k]), 32'(exp_q[k]));
      chk("rnd_done", 32'(got_done), 32'(exp_done));
      chk("rnd_err", 32'(got_err), 32'(exp_err));
      tick();
      chk("rnd_idle", 32'({done, busy}), 32'd0);
      for (int k = 0; k < $urandom_range(0, 2); k++) tick();
    end
    scramble = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
